cgra0_conf_sender: RTL

CGRA0_CONF_SENDER -- requirements
Module: cgra0_conf_sender

---
 rtl/cgra0_conf_sender.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/cgra0_conf_sender.sv
// Configuration sender: buffers upstream 64-bit words in a small FIFO and broadcasts them one per cycle.
// Optional macro CGRA0_CONF_SENDER_TYPE_CHECK_EN blanks words whose type byte exceeds 7 and flags err_type.
module cgra0_conf_sender #(
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] num_words,
  input  logic        abort,
  input  logic        conf_in_valid,
  input  logic [63:0] conf_in_data,
  output logic        conf_in_ready,
  output logic [63:0] conf_bus_out,
  output logic        busy,
  output logic        done,
  output logic [31:0] issued_count,
  output logic        err_type
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2, DONE = 2'd3} state_t;

  state_t                   state_r, state_nxt_s;
  logic [63:0]              fifo_mem_r [0:DEPTH-1];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_r, rd_ptr_r;
  logic [FIFO_DEPTH_LOG2:0] count_r;
  logic [31:0]              num_words_r, accepted_r, issued_r;
  logic [63:0]              bus_r, pop_word_s;
  logic                     err_r;
  logic                     full_s, ready_s, push_s, pop_s, pop_bad_s;
  logic                     start_acc_s, flush_s, last_pop_s;

`ifdef CGRA0_CONF_SENDER_TYPE_CHECK_EN
  function automatic logic type_bad(input logic [63:0] word);
    return word[7:0] > 8'd7;
  endfunction
`endif

  // Handshake, pop and control decode
  always_comb begin
    full_s      = count_r[FIFO_DEPTH_LOG2];
    ready_s     = (state_r == RUN) && !full_s && (accepted_r < num_words_r) && !abort;
    push_s      = conf_in_valid && ready_s;
    pop_s       = (state_r == RUN) && (count_r != '0) && !abort;
    pop_word_s  = fifo_mem_r[rd_ptr_r];
    start_acc_s = (state_r == IDLE) && start;
    flush_s     = abort && ((state_r == RUN) || (state_r == FLUSH));
    last_pop_s  = pop_s && ((issued_r + 32'd1) == num_words_r);
`ifdef CGRA0_CONF_SENDER_TYPE_CHECK_EN
    pop_bad_s   = type_bad(pop_word_s);
`else
    pop_bad_s   = 1'b0;
`endif
  end

  // Next-state logic; abort beats the final pop
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = (num_words == 32'd0) ? DONE : RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt_s = IDLE;
        end else if (last_pop_s) begin
          state_nxt_s = FLUSH;
        end else begin
          state_nxt_s = RUN;
        end
      end
      FLUSH:   state_nxt_s = abort ? IDLE : DONE;
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= conf_in_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst || flush_s) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + FIFO_DEPTH_LOG2'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + FIFO_DEPTH_LOG2'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (FIFO_DEPTH_LOG2 + 1)'(1);
        2'b01:   count_r <= count_r - (FIFO_DEPTH_LOG2 + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Burst counters; issued count survives abort and idle
  always_ff @(posedge clk) begin
    if (rst) begin
      num_words_r <= 32'd0;
      accepted_r  <= 32'd0;
      issued_r    <= 32'd0;
    end else if (start_acc_s) begin
      num_words_r <= num_words;
      accepted_r  <= 32'd0;
      issued_r    <= 32'd0;
    end else begin
      if (push_s) accepted_r <= accepted_r + 32'd1;
      if (pop_s)  issued_r   <= issued_r + 32'd1;
    end
  end

  // Broadcast register: zero whenever nothing is popped
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_r <= 64'd0;
    end else if (pop_s && !pop_bad_s) begin
      bus_r <= pop_word_s;
    end else begin
      bus_r <= 64'd0;
    end
  end

  // Sticky type-error flag
  always_ff @(posedge clk) begin
    if (rst || start_acc_s) begin
      err_r <= 1'b0;
    end else if (pop_s && pop_bad_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign conf_in_ready = ready_s;
  assign conf_bus_out  = bus_r;
  assign busy          = (state_r != IDLE);
  assign done          = (state_r == DONE);
  assign issued_count  = issued_r;
  assign err_type      = err_r;

endmodule
